// File: rtl/sram_ctrl_if.sv
// Bus-side RAM port between the CPU bus and sram_ctrl.
// master drives requests, slave returns read data and stall.
interface sram_ctrl_if;
  logic [23:0] ram_addr;
  logic [31:0] write_data_to_ram;
  logic [3:0]  ram_enable;
  logic        ram_read_enable;
  logic        ram_write_enable;
  logic [31:0] read_data_from_ram;
  logic        ram_stall;

  modport master (
    output ram_addr,
    output write_data_to_ram,
    output ram_enable,
    output ram_read_enable,
    output ram_write_enable,
    input  read_data_from_ram,
    input  ram_stall
  );

  modport slave (
    input  ram_addr,
    input  write_data_to_ram,
    input  ram_enable,
    input  ram_read_enable,
    input  ram_write_enable,
    output read_data_from_ram,
    output ram_stall
  );
endinterface

// File: rtl/sram_ctrl.sv
// Multi-cycle bus-to-async-SRAM controller; stalls the bus until done.
// Ports: clk, rst (async high), bus (RAM port), sram_* (chip pins).
module sram_ctrl #(
  parameter int ADDR_WIDTH = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_ctrl_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_o,
  input  logic [31:0]           sram_data_i,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, WHOLD, DONE
  } state_t;

  localparam logic [3:0] RD_INIT = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_INIT = 4'(WRITE_WAIT - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [31:0]           r_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_dout;
  logic                  r_doe;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic [3:0]            r_be_n;

  logic w_req;
  logic w_unused_addr;

  assign w_req = bus.ram_read_enable | bus.ram_write_enable;
  // Upper address bits beyond the SRAM are intentionally dropped.
  assign w_unused_addr = ^bus.ram_addr;

  assign bus.ram_stall          = w_req & (r_state != DONE);
  assign bus.read_data_from_ram = r_rdata;

  assign sram_addr    = r_addr;
  assign sram_data_o  = r_dout;
  assign sram_data_oe = r_doe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_be_n    = r_be_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_doe   <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_be_n  <= 4'hF;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr <= bus.ram_addr[ADDR_WIDTH-1:0];
            r_dout <= bus.write_data_to_ram;
            if (bus.ram_write_enable) begin
              // No lanes enabled: nothing to do on the chip.
              if (bus.ram_enable == 4'h0) begin
                r_state <= DONE;
              end else begin
                r_state <= WRITE;
                r_ce_n  <= 1'b0;
                r_we_n  <= 1'b0;
                r_be_n  <= ~bus.ram_enable;
                r_doe   <= 1'b1;
                r_cnt   <= WR_INIT;
              end
            end else begin
              r_state <= READ;
              r_ce_n  <= 1'b0;
              r_oe_n  <= 1'b0;
              r_be_n  <= 4'h0;
              r_cnt   <= RD_INIT;
            end
          end
        end
        READ: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= sram_data_i;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_be_n  <= 4'hF;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WRITE: begin
          // Release we_n first; addr/data stay for the hold cycle.
          if (r_cnt == 4'd0) begin
            r_we_n  <= 1'b1;
            r_state <= WHOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WHOLD: begin
          r_ce_n  <= 1'b1;
          r_be_n  <= 4'hF;
          r_doe   <= 1'b0;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural async SRAM.
// Scoreboard holds expected per-access latency, strobes and data.
module tb_sram_ctrl;
  localparam int RW = 2;
  localparam int WW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_o;
  logic [31:0] sram_data_i;
  logic        sram_data_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  sram_ctrl_if bus ();

  sram_ctrl #(
    .ADDR_WIDTH (20),
    .READ_WAIT  (RW),
    .WRITE_WAIT (WW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .sram_addr    (sram_addr),
    .sram_data_o  (sram_data_o),
    .sram_data_i  (sram_data_i),
    .sram_data_oe (sram_data_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_be_n    (sram_be_n)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];

  assign sram_data_i = (!sram_ce_n && !sram_oe_n)
                     ? mem[sram_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (!rst && !sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n[b])
          mem[sram_addr[7:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          lat;
    int          ce;
    int          oe;
    int          we;
    int          doe;
    logic [3:0]  be_n;
    logic [19:0] addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];

  int          m_lat, m_ce, m_oe, m_we, m_doe;
  logic [3:0]  m_be_n;
  logic [19:0] m_addr;
  int          n_done = 0;
  int          n_viol = 0;

  always @(negedge clk) begin
    if (!sram_oe_n && sram_data_oe) n_viol++;
    if (!sram_oe_n && !sram_we_n) n_viol++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      m_lat = 0; m_ce = 0; m_oe = 0; m_we = 0; m_doe = 0;
    end else if (bus.ram_read_enable || bus.ram_write_enable) begin
      if (!sram_ce_n) begin
        m_ce++;
        m_addr = sram_addr;
      end
      if (!sram_oe_n) begin
        m_oe++;
        m_be_n = sram_be_n;
      end
      if (!sram_we_n) begin
        m_we++;
        m_be_n = sram_be_n;
      end
      if (sram_data_oe) m_doe++;
      if (bus.ram_stall) begin
        m_lat++;
      end else if (q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("latency", m_lat, e.lat);
        check("ce_cycles", m_ce, e.ce);
        check("oe_cycles", m_oe, e.oe);
        check("we_cycles", m_we, e.we);
        check("doe_cycles", m_doe, e.doe);
        check("rdata", bus.read_data_from_ram, e.rdata);
        if (e.ce != 0) begin
          check("sram_addr", {12'h0, m_addr}, {12'h0, e.addr});
          check("be_n", {28'h0, m_be_n}, {28'h0, e.be_n});
        end
        m_lat = 0; m_ce = 0; m_oe = 0; m_we = 0; m_doe = 0;
        n_done++;
      end
    end
  end

  logic [31:0] last_rd = 32'h0;

  task automatic access(bit rd, bit wr, logic [23:0] a,
                        logic [31:0] d, logic [3:0] be,
                        logic [31:0] rexp);
    exp_t e;
    int   base;
    e.addr = a[19:0];
    if (wr) begin
      e.rdata = last_rd;
      e.oe    = 0;
      if (be == 4'h0) begin
        e.lat = 1; e.ce = 0; e.we = 0; e.doe = 0;
        e.be_n = 4'hF;
      end else begin
        e.lat = WW + 2; e.ce = WW + 1;
        e.we = WW; e.doe = WW + 1;
        e.be_n = ~be;
      end
    end else begin
      e.rdata = rexp;
      last_rd = rexp;
      e.lat = RW + 1; e.ce = RW; e.oe = RW;
      e.we = 0; e.doe = 0; e.be_n = 4'h0;
    end
    q.push_back(e);
    bus.ram_read_enable   = rd;
    bus.ram_write_enable  = wr;
    bus.ram_addr          = a;
    bus.write_data_to_ram = d;
    bus.ram_enable        = be;
    base = n_done;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (n_done != base) break;
    end
    if (n_done == base) begin
      check("timeout", 32'd1, 32'd0);
      q.delete();
    end
    #1;
  endtask

  task automatic idle();
    bus.ram_read_enable  = 1'b0;
    bus.ram_write_enable = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 | i;
    mem[8'h23] = 32'hDEADBEEF;
    mem[8'hDE] = 32'hAAAAAAAA;
    mem[8'h10] = 32'h11111111;
    bus.ram_addr          = '0;
    bus.write_data_to_ram = '0;
    bus.ram_enable        = '0;
    idle();
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_strobes",
          {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, 1'b0},
          {27'h0, 5'b11100});
    check("rst_be_n", {28'h0, sram_be_n}, 32'hF);
    check("rst_addr", {12'h0, sram_addr}, 32'h0);
    check("rst_dout", sram_data_o, 32'h0);
    check("rst_rdata", bus.read_data_from_ram, 32'h0);
    check("rst_stall", {31'h0, bus.ram_stall}, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    access(1, 0, 24'h000123, 32'h0, 4'h0, 32'hDEADBEEF);
    idle();
    @(posedge clk) #1;

    access(0, 1, 24'h0ABCDE, 32'h12345678, 4'b0101, 32'h0);
    idle();
    @(posedge clk) #1;
    check("mem_be_write", mem[8'hDE], 32'hAA34AA78);
    access(1, 0, 24'h0ABCDE, 32'h0, 4'h0, 32'hAA34AA78);
    idle();
    @(posedge clk) #1;

    access(0, 1, 24'h000010, 32'hFFFFFFFF, 4'h0, 32'h0);
    idle();
    @(posedge clk) #1;
    check("mem_zero_be", mem[8'h10], 32'h11111111);

    access(1, 1, 24'h000010, 32'hCAFEF00D, 4'hF, 32'h0);
    idle();
    @(posedge clk) #1;
    check("mem_rw_both", mem[8'h10], 32'hCAFEF00D);
    access(1, 0, 24'h000010, 32'h0, 4'h0, 32'hCAFEF00D);
    idle();
    @(posedge clk) #1;

    access(1, 0, 24'h000123, 32'h0, 4'h0, 32'hDEADBEEF);
    access(0, 1, 24'h000040, 32'h0BADF00D, 4'hF, 32'h0);
    access(1, 0, 24'h000040, 32'h0, 4'h0, 32'h0BADF00D);
    access(1, 0, 24'h000040, 32'h0, 4'h0, 32'h0BADF00D);
    idle();
    @(posedge clk) #1;

    bus.ram_write_enable  = 1'b1;
    bus.ram_addr          = 24'h000080;
    bus.write_data_to_ram = 32'h55667788;
    bus.ram_enable        = 4'hF;
    @(posedge clk);
    #3;
    check("pre_rst_we", {31'h0, sram_we_n}, 32'h0);
    rst = 1'b1;
    idle();
    #1;
    check("arst_strobes",
          {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, 1'b0},
          {27'h0, 5'b11100});
    check("arst_be_n", {28'h0, sram_be_n}, 32'hF);
    check("arst_stall", {31'h0, bus.ram_stall}, 32'h0);
    check("arst_rdata", bus.read_data_from_ram, 32'h0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    access(1, 0, 24'hF00123, 32'h0, 4'h0, 32'hDEADBEEF);
    idle();
    @(posedge clk) #1;

    check("protocol_overlap", n_viol, 32'd0);
    check("sb_leftover", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
